// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap sequencer: masked fixed-priority IRQ entry, mret return, CSRs.
// Define TRAP_VECTORED_EN to vector trap entry to mtvec + taken line index.
module trap_controller #(
   parameter int NUM_IRQ      = 8,
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int MTVEC_RESET  = 36
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [XLEN-1:0]    i_fetch_pc,
   input  logic               i_branch_busy,
   input  logic               i_mret,
   input  logic               i_csr_we,
   input  logic [1:0]         i_csr_addr,
   input  logic [XLEN-1:0]    i_csr_wdata,
   output logic [XLEN-1:0]    o_csr_rdata,
   output logic               o_stall,
   output logic               o_redirect,
   output logic [XLEN-1:0]    o_redirect_pc,
   output logic               o_in_trap,
   output logic [NUM_IRQ-1:0] o_trap_ack
);

   localparam int IW = 5;
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_ENTER_JMP,
      S_HANDLER,
      S_EXIT,
      S_EXIT_JMP
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [NUM_IRQ-1:0] r_mie;
   logic [XLEN-1:0]    r_mtvec;
   logic [XLEN-1:0]    r_mepc;
   logic [XLEN-1:0]    r_mcause;
   logic               r_stall;
   logic               r_redirect;
   logic [XLEN-1:0]    r_redirect_pc;
   logic               r_in_trap;
   logic [NUM_IRQ-1:0] r_ack;

   state_t             w_state_nxt;
   logic [CW-1:0]      w_cnt_nxt;
   logic               w_take;
   logic [NUM_IRQ-1:0] w_pend;
   logic [IW-1:0]      w_idx;
   logic [XLEN-1:0]    w_cause;
   logic [NUM_IRQ-1:0] w_mie_nxt;
   logic [XLEN-1:0]    w_mtvec_nxt;
   logic [XLEN-1:0]    w_mepc_nxt;
   logic [XLEN-1:0]    w_mcause_nxt;
   logic [XLEN-1:0]    w_vec_pc;
   logic               w_stall_nxt;
   logic               w_redirect_nxt;
   logic               w_in_trap_nxt;
   logic [XLEN-1:0]    w_pc_nxt;
   logic [NUM_IRQ-1:0] w_ack_nxt;

   assign w_pend  = i_irq & r_mie;
   assign w_cause = XLEN'(w_idx) | (XLEN'(1) << (XLEN - 1));

   // Lowest set index has priority: scan downward so the last hit wins.
   always_comb begin
      w_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[i]) w_idx = IW'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((|w_pend) && !i_branch_busy) begin
               w_take      = 1'b1;
               w_state_nxt = S_ENTER;
               w_cnt_nxt   = '0;
            end
         end
         S_ENTER: begin
            if (r_cnt == LAST) w_state_nxt = S_ENTER_JMP;
            else               w_cnt_nxt   = r_cnt + 1'b1;
         end
         S_ENTER_JMP: w_state_nxt = S_HANDLER;
         S_HANDLER: begin
            if (i_mret) begin
               w_state_nxt = S_EXIT;
               w_cnt_nxt   = '0;
            end
         end
         S_EXIT: begin
            if (r_cnt == LAST) w_state_nxt = S_EXIT_JMP;
            else               w_cnt_nxt   = r_cnt + 1'b1;
         end
         S_EXIT_JMP: w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Hardware capture overrides a same-cycle software write.
   always_comb begin
      w_mie_nxt    = (i_csr_we && i_csr_addr == 2'd0) ? i_csr_wdata[NUM_IRQ-1:0] : r_mie;
      w_mtvec_nxt  = (i_csr_we && i_csr_addr == 2'd1) ? i_csr_wdata : r_mtvec;
      w_mepc_nxt   = w_take ? i_fetch_pc :
                     (i_csr_we && i_csr_addr == 2'd2) ? i_csr_wdata : r_mepc;
      w_mcause_nxt = w_take ? w_cause :
                     (i_csr_we && i_csr_addr == 2'd3) ? i_csr_wdata : r_mcause;
   end

`ifdef TRAP_VECTORED_EN
   logic [IW-1:0] r_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_idx <= '0;
      else if (w_take) r_idx <= w_idx;
   end

   assign w_vec_pc = w_mtvec_nxt + XLEN'(r_idx);
`else
   assign w_vec_pc = w_mtvec_nxt;
`endif

   // Outputs are decoded from the next state so they are registered yet aligned with it;
   // redirect targets use forwarded CSR values so a write in the final drain cycle still lands.
   always_comb begin
      w_stall_nxt    = (w_state_nxt == S_ENTER) || (w_state_nxt == S_EXIT);
      w_redirect_nxt = (w_state_nxt == S_ENTER_JMP) || (w_state_nxt == S_EXIT_JMP);
      w_in_trap_nxt  = (w_state_nxt == S_ENTER_JMP) || (w_state_nxt == S_HANDLER) ||
                       (w_state_nxt == S_EXIT);
      w_ack_nxt      = w_take ? (NUM_IRQ'(1) << w_idx) : '0;
      w_pc_nxt       = '0;
      if (w_state_nxt == S_ENTER_JMP)     w_pc_nxt = w_vec_pc;
      else if (w_state_nxt == S_EXIT_JMP) w_pc_nxt = w_mepc_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_mie         <= '1;
         r_mtvec       <= XLEN'(MTVEC_RESET);
         r_mepc        <= '0;
         r_mcause      <= '0;
         r_stall       <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_in_trap     <= 1'b0;
         r_ack         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_mie         <= w_mie_nxt;
         r_mtvec       <= w_mtvec_nxt;
         r_mepc        <= w_mepc_nxt;
         r_mcause      <= w_mcause_nxt;
         r_stall       <= w_stall_nxt;
         r_redirect    <= w_redirect_nxt;
         r_redirect_pc <= w_pc_nxt;
         r_in_trap     <= w_in_trap_nxt;
         r_ack         <= w_ack_nxt;
      end
   end

   always_comb begin
      case (i_csr_addr)
         2'd0:    o_csr_rdata = XLEN'(r_mie);
         2'd1:    o_csr_rdata = r_mtvec;
         2'd2:    o_csr_rdata = r_mepc;
         default: o_csr_rdata = r_mcause;
      endcase
   end

   assign o_stall       = r_stall;
   assign o_redirect    = r_redirect;
   assign o_redirect_pc = r_redirect_pc;
   assign o_in_trap     = r_in_trap;
   assign o_trap_ack    = r_ack;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
Parametrised machine-mode trap sequencer for the core pipeline. It handles NUM_IRQ level-sensitive interrupt lines with masking and fixed priority. It owns the mie, mtvec, mepc and mcause CSRs. It drives decoder stall and PC redirect for trap entry and for mret return, replacing the fixed single-line interrupt counter sequence in the core.

Parameters:
NUM_IRQ, 8, number of interrupt lines (1..32)
XLEN, 32, width of PC and CSR data
DRAIN_CYCLES, 2, stall cycles before each redirect (>=1); covers the execute and write stages
MTVEC_RESET, 36, reset value of mtvec (instruction-indexed PC)

Ports:
CLK  input  1  clock
RSTN  input  1  reset, asynchronous, active-low
IRQ  input  NUM_IRQ  level interrupt requests
FETCH_PC  input  XLEN  PC of the instruction in fetch; captured into mepc
BRANCH_BUSY  input  1  conditional-jump stall in progress; defers trap entry
MRET  input  1  decoder has decoded mret (single-cycle pulse)
CSR_WE  input  1  CSR write strobe
CSR_ADDR  input  2  0=mie, 1=mtvec, 2=mepc, 3=mcause
CSR_WDATA  input  XLEN  CSR write data
CSR_RDATA  output  XLEN  combinational read of the CSR at CSR_ADDR
STALL  output  1  disable decoder
REDIRECT  output  1  one-cycle pulse: core loads REDIRECT_PC into pc
REDIRECT_PC  output  XLEN  redirect target
IN_TRAP  output  1  machine mode
TRAP_ACK  output  NUM_IRQ  one-hot pulse identifying the taken line

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RSTN low clears immediately, independent of CLK).
- Reset values:
  - STALL, REDIRECT, IN_TRAP, TRAP_ACK, REDIRECT_PC = 0.
  - mie = all ones (lower NUM_IRQ bits); mtvec = MTVEC_RESET; mepc = 0; mcause = 0.
  - State = IDLE.
- Register rules: all outputs except CSR_RDATA are registered. Unused upper mie bits read 0.
- FSM states: IDLE, ENTER, ENTER_JMP, HANDLER, EXIT, EXIT_JMP.
- IDLE:
  - pend = IRQ & mie.
  - If pend != 0 and BRANCH_BUSY = 0: pick the lowest set index k.
  - Capture mepc <= FETCH_PC and mcause <= {1'b1, k zero-extended}.
  - Next cycle: STALL = 1, TRAP_ACK bit k pulses for one cycle. Go to ENTER.
- ENTER: STALL held for DRAIN_CYCLES cycles in total (counting the ACK cycle), then go to ENTER_JMP.
- ENTER_JMP (one cycle):
  - REDIRECT = 1, REDIRECT_PC = mtvec, STALL = 0, IN_TRAP = 1.
  - Go to HANDLER.
- HANDLER:
  - IRQ is ignored (no nesting).
  - On MRET: STALL = 1 next cycle and go to EXIT.
- EXIT: STALL held DRAIN_CYCLES cycles, then go to EXIT_JMP.
- EXIT_JMP (one cycle):
  - REDIRECT = 1, REDIRECT_PC = mepc, STALL = 0, IN_TRAP = 0.
  - Go to IDLE.
- Trap latency: IRQ assertion to REDIRECT = DRAIN_CYCLES+1 cycles.
- MRET outside HANDLER: ignored.
- Simultaneous events:
  - MRET and IRQ in HANDLER: MRET wins; a still-asserted IRQ is taken from IDLE after return. The earliest re-entry is the cycle after EXIT_JMP.
  - BRANCH_BUSY in IDLE: entry is deferred while high; IRQ is re-evaluated each cycle (level, not latched). An IRQ dropped before evaluation is lost.
  - CSR write to mepc/mcause in the same cycle as a hardware capture: the capture wins.
  - CSR write of mepc in HANDLER: the return uses the new value.
  - CSR write of mtvec during ENTER: it takes effect if written before ENTER_JMP.
- CSR write timing: CSR writes take effect the next cycle; CSR_RDATA reflects register contents.
- Reset mid-sequence: immediate return to IDLE with reset values. No redirect is issued.

Optional Feature:
TRAP_VECTORED_EN:
- Defined: in ENTER_JMP, REDIRECT_PC = mtvec + k, where k is the taken line index (mcause low bits).
- Undefined: REDIRECT_PC = mtvec for all causes.
- Return path is identical in both cases.

Test Plan:
- Defaults; FETCH_PC=10; IRQ=8'h01 for one cycle in IDLE:
  - ACK cycle: STALL=1 and TRAP_ACK=8'h01; mepc=10 and mcause=0x80000000.
  - STALL held 2 cycles, then REDIRECT=1, REDIRECT_PC=36, IN_TRAP=1.
- IRQ=8'h28: mcause=0x80000003, TRAP_ACK=8'h08. With TRAP_VECTORED_EN, REDIRECT_PC=39.
- BRANCH_BUSY=1 for 3 cycles with IRQ=8'h02 held: STALL stays 0 throughout. TRAP_ACK=8'h02 appears one cycle after BRANCH_BUSY falls.
- In HANDLER: MRET pulse with IRQ=8'h02 held:
  - 2 stall cycles, then REDIRECT_PC=10 and IN_TRAP=0.
  - Next cycle re-entry with mcause=0x80000001.
- Masking and mepc override:
  - Write mie=0, then IRQ=8'hFF: no STALL for 10 cycles.
  - Restore mie and take a trap; write mepc=20 in HANDLER then MRET: REDIRECT_PC=20.
- RSTN low during ENTER: STALL=0, REDIRECT=0 and IN_TRAP=0 immediately (asynchronously). mtvec=36 after release.
